// File: rtl/fifo_uart_drain.sv
// Drain side of the two-clock FIFO: pops one word at a time on the read clock and
// sends it as an async serial frame (start, LSB-first data, optional even parity, stop).
module fifo_uart_drain #(
    parameter int DATA_SIZE = 4,
    parameter int BAUD_DIV  = 4,
    parameter int PARITY_EN = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 fifo_empty,
    input  logic                 fifo_valid,
    input  logic [DATA_SIZE-1:0] fifo_data,
    output logic                 fifo_read,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int BCW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int DCW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
    localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 1);
    localparam logic [DCW-1:0] BIT_LAST  = DCW'(DATA_SIZE - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_REQ, ST_WAIT, ST_START, ST_DATA, ST_PARITY, ST_STOP
    } state_t;

    state_t               state;
    logic [DATA_SIZE-1:0] shift_reg;
    logic [DATA_SIZE-1:0] shift_next;
    logic                 parity_bit;
    logic [DCW-1:0]       bit_cnt;
    logic [BCW-1:0]       baud_cnt;
    logic                 baud_tick;

    assign shift_next = shift_reg >> 1;
    assign baud_tick  = (baud_cnt == BAUD_LAST);

    // NOTE: every output is loaded on the same edge as the state it belongs to, so
    // all outputs are registered Moore values with no path from any input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            tx         <= 1'b1;
            fifo_read  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            bit_cnt    <= '0;
            baud_cnt   <= '0;
        end else begin
            // NOTE: non-blocking throughout, so every branch reads pre-edge values.
            fifo_read <= 1'b0;
            done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tx <= 1'b1;
                    if (enable && !fifo_empty) begin
                        state     <= ST_REQ;
                        fifo_read <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ST_REQ: state <= ST_WAIT;
                ST_WAIT: begin
                    // Parity is captured here because the shift register is consumed.
                    if (fifo_valid) begin
                        shift_reg  <= fifo_data;
                        parity_bit <= ^fifo_data;
                        baud_cnt   <= '0;
                        tx         <= 1'b0;
                        state      <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_tick) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= shift_reg[0];
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BCW'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_tick) begin
                        baud_cnt  <= '0;
                        shift_reg <= shift_next;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                tx    <= parity_bit;
                                state <= ST_PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= ST_STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + DCW'(1);
                            tx      <= shift_next[0];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BCW'(1);
                    end
                end
                ST_PARITY: begin
                    if (baud_tick) begin
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                        state    <= ST_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + BCW'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_tick) begin
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + BCW'(1);
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Directed bench for fifo_uart_drain: one instance without parity, one with parity,
// each fed by a small FIFO model whose read data is valid two cycles after the request.
module tb_fifo_uart_drain;

    localparam int BAUD = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic en0   = 1'b0;
    logic en1   = 1'b0;

    logic       empty0, read0, tx0, busy0, done0;
    logic       valid0 = 1'b0;
    logic [3:0] data0  = 4'h0;
    logic       empty1, read1, tx1, busy1, done1;
    logic       valid1 = 1'b0;
    logic [3:0] data1  = 4'h0;

    logic [3:0] mem0 [16];
    logic [3:0] mem1 [16];
    logic [3:0] hold0 = 4'h0;
    logic [3:0] hold1 = 4'h0;
    int wr0 = 0, rd0 = 0, pend0 = 0, reads0 = 0;
    int wr1 = 0, rd1 = 0, pend1 = 0, reads1 = 0;

    int  vectors     = 0;
    int  miscompares = 0;
    time last_start_t = 0;
    time last_stop_t  = 0;

    assign empty0 = (rd0 == wr0);
    assign empty1 = (rd1 == wr1);

    always #5 clk = ~clk;

    fifo_uart_drain #(.DATA_SIZE(4), .BAUD_DIV(BAUD), .PARITY_EN(0)) dut0 (
        .clk(clk), .reset(reset), .enable(en0), .fifo_empty(empty0),
        .fifo_valid(valid0), .fifo_data(data0), .fifo_read(read0),
        .tx(tx0), .busy(busy0), .done(done0)
    );

    fifo_uart_drain #(.DATA_SIZE(4), .BAUD_DIV(BAUD), .PARITY_EN(1)) dut1 (
        .clk(clk), .reset(reset), .enable(en1), .fifo_empty(empty1),
        .fifo_valid(valid1), .fifo_data(data1), .fifo_read(read1),
        .tx(tx1), .busy(busy1), .done(done1)
    );

    // FIFO models: pop on the request, present the word valid two cycles later.
    always @(negedge clk) begin
        valid0 = 1'b0;
        if (reset) pend0 = 0;
        else if (pend0 == 2) pend0 = 1;
        else if (pend0 == 1) begin
            pend0 = 0; valid0 = 1'b1; data0 = hold0;
        end
        if (read0 === 1'b1) begin
            hold0 = mem0[rd0]; rd0 = rd0 + 1; pend0 = 2; reads0 = reads0 + 1;
        end
    end

    always @(negedge clk) begin
        valid1 = 1'b0;
        if (reset) pend1 = 0;
        else if (pend1 == 2) pend1 = 1;
        else if (pend1 == 1) begin
            pend1 = 0; valid1 = 1'b1; data1 = hold1;
        end
        if (read1 === 1'b1) begin
            hold1 = mem1[rd1]; rd1 = rd1 + 1; pend1 = 2; reads1 = reads1 + 1;
        end
    end

    function automatic logic tx_of(input int sel);
        return (sel == 0) ? tx0 : tx1;
    endfunction
    function automatic logic busy_of(input int sel);
        return (sel == 0) ? busy0 : busy1;
    endfunction
    function automatic logic read_of(input int sel);
        return (sel == 0) ? read0 : read1;
    endfunction
    function automatic logic done_of(input int sel);
        return (sel == 0) ? done0 : done1;
    endfunction

    task automatic push0(input logic [3:0] w);
        mem0[wr0] = w; wr0 = wr0 + 1;
    endtask
    task automatic push1(input logic [3:0] w);
        mem1[wr1] = w; wr1 = wr1 + 1;
    endtask

    task automatic wait_start(input int sel, output bit ok, output time t);
        ok = 1'b0; t = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_of(sel) === 1'b0) begin
                ok = 1'b1; t = $time;
                break;
            end
        end
    endtask

    // exp holds the frame bits in transmission order, bit 0 = start bit.
    task automatic check_frame(input int sel, input int nbits, input logic [7:0] exp,
                               input int drop_at, input string name);
        bit  ok, bad;
        time t;
        wait_start(sel, ok, t);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s start: tx=%b after 200 cycles, required 0", name, tx_of(sel));
            return;
        end
        last_start_t = t;
        for (int b = 0; b < nbits; b++) begin
            bad = 1'b0;
            for (int s = 0; s < BAUD; s++) begin
                if (b != 0 || s != 0) @(negedge clk);
                if (tx_of(sel) !== exp[b] || busy_of(sel) !== 1'b1 || read_of(sel) !== 1'b0)
                    bad = 1'b1;
                if (b * BAUD + s == drop_at) en0 = 1'b0;
            end
            vectors++;
            if (bad) begin
                miscompares++;
                $display("FAIL %s bit%0d: tx=%b busy=%b fifo_read=%b, required tx=%b busy=1 fifo_read=0",
                         name, b, tx_of(sel), busy_of(sel), read_of(sel), exp[b]);
            end
        end
        last_stop_t = $time;
        @(negedge clk);
        vectors++;
        if (done_of(sel) !== 1'b1 || busy_of(sel) !== 1'b0 || tx_of(sel) !== 1'b1) begin
            miscompares++;
            $display("FAIL %s done_pulse: done=%b busy=%b tx=%b, required done=1 busy=0 tx=1",
                     name, done_of(sel), busy_of(sel), tx_of(sel));
        end
        @(negedge clk);
        vectors++;
        if (done_of(sel) !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done_width: done=%b, required 0", name, done_of(sel));
        end
    endtask

    task automatic check_reads(input int got, input int want, input string name);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: fifo_read pulses=%0d, required %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        bit bad;
        en0 = 1'b1; en1 = 1'b1;
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (tx0 !== 1'b1 || busy0 !== 1'b0 || read0 !== 1'b0 || done0 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_dut0: tx=%b busy=%b fifo_read=%b done=%b, required 1 0 0 0",
                     tx0, busy0, read0, done0);
        end
        vectors++;
        if (tx1 !== 1'b1 || busy1 !== 1'b0 || read1 !== 1'b0 || done1 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_dut1: tx=%b busy=%b fifo_read=%b done=%b, required 1 0 0 0",
                     tx1, busy1, read1, done1);
        end
        reset = 1'b0;
        bad = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (read0 !== 1'b0 || read1 !== 1'b0 || tx0 !== 1'b1 || tx1 !== 1'b1 ||
                busy0 !== 1'b0 || busy1 !== 1'b0) bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL idle_empty: fifo_read=%b/%b tx=%b/%b busy=%b/%b, required 0/0 1/1 0/0",
                     read0, read1, tx0, tx1, busy0, busy1);
        end
        en1 = 1'b0;
    endtask

    task automatic test_single();
        int base = reads0;
        push0(4'b1010);
        check_frame(0, 6, 8'b0011_0100, -1, "single_1010");
        check_reads(reads0 - base, 1, "single_reads");
    endtask

    task automatic test_parity();
        int base = reads1;
        push1(4'b0111);
        push1(4'b0110);
        en1 = 1'b1;
        check_frame(1, 7, 8'b0110_1110, -1, "parity_0111");
        check_frame(1, 7, 8'b0100_1100, -1, "parity_0110");
        en1 = 1'b0;
        check_reads(reads1 - base, 2, "parity_reads");
    endtask

    task automatic test_back_to_back();
        int  base = reads0;
        int  gap;
        time stop1;
        push0(4'h3);
        push0(4'hC);
        check_frame(0, 6, 8'b0010_0110, -1, "b2b_first");
        stop1 = last_stop_t;
        check_frame(0, 6, 8'b0011_1000, -1, "b2b_second");
        gap = int'((last_start_t - stop1) / 10) - 1;
        vectors++;
        if (gap < 4) begin
            miscompares++;
            $display("FAIL b2b_gap: %0d idle cycles between frames, required >= 4", gap);
        end
        check_reads(reads0 - base, 2, "b2b_reads");
    endtask

    task automatic test_enable_gating();
        int base = reads0;
        bit bad = 1'b0;
        push0(4'h5);
        push0(4'h9);
        check_frame(0, 6, 8'b0010_1010, 6, "gate_first");
        repeat (30) begin
            @(negedge clk);
            if (read0 !== 1'b0 || tx0 !== 1'b1 || busy0 !== 1'b0) bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL gate_hold: fifo_read=%b tx=%b busy=%b, required 0 1 0", read0, tx0, busy0);
        end
        check_reads(reads0 - base, 1, "gate_reads_held");
        en0 = 1'b1;
        check_frame(0, 6, 8'b0011_0010, -1, "gate_second");
        check_reads(reads0 - base, 2, "gate_reads_total");
    endtask

    task automatic test_reset_mid_frame();
        int  base = reads0;
        bit  ok;
        time t;
        push0(4'h5);
        push0(4'h6);
        wait_start(0, ok, t);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL midreset_start: tx=%b after 200 cycles, required 0", tx0);
        end
        repeat (9) @(negedge clk);
        vectors++;
        if (tx0 !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_bit1: tx=%b, required 0", tx0);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (tx0 !== 1'b1 || busy0 !== 1'b0 || read0 !== 1'b0 || done0 !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_async: tx=%b busy=%b fifo_read=%b done=%b, required 1 0 0 0",
                     tx0, busy0, read0, done0);
        end
        @(negedge clk);
        reset = 1'b0;
        check_frame(0, 6, 8'b0010_1100, -1, "midreset_fresh");
        check_reads(reads0 - base, 2, "midreset_reads");
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_back_to_back();
        test_enable_gating();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_uart_drain.md
Name: fifo_uart_drain

Overview:
- Read-side consumer for the team's two-clock FIFO: pulls words from the FIFO read port and serialises each one onto a single-wire asynchronous line.
- Frame format: start bit, data LSB first, optional even parity, stop bit.
- Sits on the clk_read domain; its clock is the FIFO's read clock.
- Provides the drain end of the FIFO path so buffered data leaves the chip without a host polling data_out.

Parameters:
- DATA_SIZE, 4, width of one FIFO word and of the serial data field.
- BAUD_DIV, 4, clock cycles per serial bit; legal range 1 or more; counter width $clog2(BAUD_DIV), minimum 1.
- PARITY_EN, 0, 1 inserts an even-parity bit between the last data bit and the stop bit.

Ports:
- clk  input  1  single clock for all logic; connected to the FIFO's clk_read.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  permits starting new frames; does not abort a frame in progress.
- fifo_empty  input  1  FIFO empty flag.
- fifo_valid  input  1  FIFO read-data valid, high the cycle after an accepted read.
- fifo_data  input  DATA_SIZE  FIFO data_out.
- fifo_read  output  1  read request to the FIFO read_mode; one-cycle pulse.
- tx  output  1  serial line; idles high.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the stop bit completes.

Behaviour:
- Reset values (asynchronous, applied immediately): state IDLE, tx=1, fifo_read=0, busy=0, done=0, shift register 0, bit counter 0, baud counter 0.
- Outputs are Moore, decoded from registered state; no combinational path from any input to any output.
- States and transitions:
  - IDLE: tx=1. If enable and !fifo_empty, go to REQ next edge.
  - REQ: exactly one cycle, fifo_read=1. Always go to WAIT.
  - WAIT: fifo_read=0. On fifo_valid=1, latch fifo_data into the shift register, clear the baud counter, go to START. Otherwise stay; there is no timeout.
  - START: tx=0 for BAUD_DIV cycles, then go to DATA with bit counter 0.
  - DATA: tx=shift[0] for BAUD_DIV cycles, then shift right and increment the bit counter. After DATA_SIZE bits, go to PARITY if PARITY_EN, else STOP.
  - PARITY: tx = XOR of the latched word (even parity) for BAUD_DIV cycles, then go to STOP.
  - STOP: tx=1 for BAUD_DIV cycles, then go to IDLE and assert done for that single following cycle.
- Frame length: (DATA_SIZE + 2 + PARITY_EN) × BAUD_DIV cycles, START through STOP inclusive.
- Back-to-back frames: IDLE always lasts at least one cycle, so the gap between a stop bit and the next start bit is ≥ 4 cycles (IDLE + REQ + WAIT + 1 cycle of FIFO latency, as seen on tx).
- Only one FIFO read is outstanding at a time; a second read is never issued before the current word is latched.
- enable dropped mid-frame: the current frame completes normally; no new REQ is issued until enable returns high.
- fifo_empty rising while in WAIT: ignored; the block still waits for fifo_valid.
- Reset mid-frame: tx returns to 1 at once; the partial frame is abandoned; the word already popped from the FIFO is lost.
- BAUD_DIV=1: every bit lasts exactly one cycle; the baud counter is unused but legal.

Test Plan:
1. Reset and idle: assert reset with fifo_empty=1 -> tx=1, busy=0, fifo_read=0 throughout; no REQ for 50 cycles after release.
2. Single word (DATA_SIZE=4, BAUD_DIV=4, PARITY_EN=0): FIFO holds 4'b1010 -> one fifo_read pulse; tx = 0,0,1,0,1 bits then 1, each bit 4 cycles (24 cycles total); done pulses once; busy falls with done.
3. Parity (PARITY_EN=1): word 4'b0111 -> parity bit 1; word 4'b0110 -> parity bit 0; frame 28 cycles each.
4. Back-to-back: FIFO preloaded with 4'h3, 4'hC -> two frames in order; exactly two fifo_read pulses; start bit of frame 2 begins ≥ 4 cycles after stop of frame 1 ends; data bits 1,1,0,0 then 0,0,1,1.
5. Enable gating: drop enable during DATA of frame 1 with 2 words queued -> frame 1 completes; no fifo_read until enable reasserted; then frame 2 sent.
6. Reset mid-frame: assert reset during the second data bit -> tx=1 within the same cycle; state IDLE; after release with FIFO non-empty, a fresh REQ and complete frame follow.
